// File: rtl/note_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// note_sequencer_pkg
// Shared constants, state encoding and song-word field helpers for the
// note_sequencer playback engine.
//   SONG_WORD_W : width of one song ROM word
//   DUR_LSB     : lowest bit of the duration field inside a song word
//   DUR_W       : width of the duration field (ticks to hold a chord)
//   NOTES_W     : width of the three-voice notes payload
// -----------------------------------------------------------------------------
package note_sequencer_pkg;

    localparam int SONG_WORD_W = 32;
    localparam int DUR_LSB     = 27;
    localparam int DUR_W       = 5;
    localparam int NOTES_W     = 27;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // Duration field of a song word; zero marks the end of the song.
    function automatic logic [DUR_W-1:0] word_dur(input logic [SONG_WORD_W-1:0] word);
        return word[DUR_LSB +: DUR_W];
    endfunction

    // Three-voice chord payload of a song word.
    function automatic logic [NOTES_W-1:0] word_notes(input logic [SONG_WORD_W-1:0] word);
        return word[NOTES_W-1:0];
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// -----------------------------------------------------------------------------
// note_sequencer_if
// Song ROM bus between the sequencer and an external synchronous ROM.
//   rom_addr : word address driven by the sequencer
//   rom_data : song word, valid one cycle after rom_addr is sampled
// Modports:
//   master : sequencer side (drives rom_addr)
//   slave  : ROM side (drives rom_data)
// -----------------------------------------------------------------------------
interface note_sequencer_if #(
    parameter int ADDR_W = 8
);
    import note_sequencer_pkg::*;

    logic [ADDR_W-1:0]      rom_addr;
    logic [SONG_WORD_W-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);

endinterface

// File: rtl/note_sequencer_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to the tempo tick. Counts 0..TICK_DIV-1 while enabled and
// wraps; tick is a one-cycle strobe on the enabled cycle where the count is at
// its last value. clear forces the count back to zero and wins over enable.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : advance the count this cycle
//   clear      : restart the count from zero
//   tick       : tempo tick strobe
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 6000,
    parameter int TICK_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] count_q, count_d;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
// Song playback engine feeding the three-voice note decoder. Fetches 32-bit
// song words from a synchronous ROM, holds each chord for dur tempo ticks and
// advances; a word with dur = 0 ends the song or, with loop high, restarts it
// at the latched start address.
// Parameters:
//   ADDR_W   : song ROM address width
//   TICK_DIV : clk cycles per tempo tick (>= 1)
//   TICK_W   : prescaler width, 2^TICK_W >= TICK_DIV
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   play       : start/restart pulse, samples start_addr
//   stop       : stop pulse (highest priority)
//   pause      : level, freezes the hold timer while holding a chord
//   loop       : level, restart at the start address on an end marker
//   start_addr : first song word address
//   rom        : song ROM bus (master side)
//   notes      : per voice v, [9v+6:9v] note index, [9v+8:9v+7] waveform
//   playing    : high in any state except IDLE
//   song_done  : one-cycle pulse on a non-looped end marker
// -----------------------------------------------------------------------------
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int TICK_DIV = 6000,
    parameter int TICK_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 play,
    input  logic                 stop,
    input  logic                 pause,
    input  logic                 loop,
    input  logic [ADDR_W-1:0]    start_addr,
    note_sequencer_if.master     rom,
    output logic [NOTES_W-1:0]   notes,
    output logic                 playing,
    output logic                 song_done
);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    ptr_q, ptr_d;
    logic [ADDR_W-1:0]    start_q, start_d;
    logic [NOTES_W-1:0]   notes_q, notes_d;
    logic [DUR_W-1:0]     dur_q, dur_d;
    logic                 song_done_q, song_done_d;

    logic                 tick;
    logic                 presc_en;
    logic                 presc_clr;
    logic [DUR_W-1:0]     rom_dur;

    assign rom_dur   = word_dur(rom.rom_data);

    // The tempo timer only runs while a chord is held and not paused; every
    // new chord starts from a fresh tick boundary.
    assign presc_en  = (state_q == HOLD) && !pause;
    assign presc_clr = (state_q == LOAD);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_tick_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (presc_en),
        .clear  (presc_clr),
        .tick   (tick)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        start_d     = start_q;
        notes_d     = notes_q;
        dur_d       = dur_q;
        song_done_d = 1'b0;

        if (stop) begin
            state_d = IDLE;
            notes_d = '0;
        end else if (play) begin
            // Restart from any state; the current chord keeps sounding until
            // the first word of the new run is loaded.
            ptr_d   = start_addr;
            start_d = start_addr;
            state_d = FETCH;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                FETCH: begin
                    state_d = LOAD;
                end
                LOAD: begin
                    if (rom_dur != '0) begin
                        notes_d = word_notes(rom.rom_data);
                        dur_d   = rom_dur;
                        ptr_d   = ptr_q + 1'b1;
                        state_d = HOLD;
                    end else if (loop) begin
                        // notes untouched: the last chord bridges the wrap
                        ptr_d   = start_q;
                        state_d = FETCH;
                    end else begin
                        notes_d     = '0;
                        song_done_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        dur_d = dur_q - 1'b1;
                        if (dur_q == DUR_W'(1)) begin
                            state_d = FETCH;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            start_q     <= '0;
            notes_q     <= '0;
            dur_q       <= '0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            start_q     <= start_d;
            notes_q     <= notes_d;
            dur_q       <= dur_d;
            song_done_q <= song_done_d;
        end
    end

    assign rom.rom_addr = ptr_q;
    assign notes        = notes_q;
    assign playing      = (state_q != IDLE);
    assign song_done    = song_done_q;

endmodule
